booth_mult_param: RTL and testbench
===================================

Name: booth_mult_param

Overview:
- Parametrised, sequential radix-4 Booth multiplier for the processor's multdiv unit. Successor of the fixed 32-bit signed multiplier.
- Adds configurable WIDTH, a per-operation signed/unsigned mode and full 2*WIDTH product output.
- Adds an explicit IDLE/RUN/DONE state machine with busy, synchronous reset and restart-on-start semantics.
- Sits beside the divider in multdiv. The processor stalls on busy and consumes the result on data_resultRDY.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- Derived (localparam, not overridable): EW = WIDTH+2 extended operand width; NITER = EW/2 iteration count; CW = clog2(NITER+1) counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_MULT  in  1  start pulse; operands and mode sampled on the same edge.
- data_signed  in  1  1 = two's-complement operands, 0 = unsigned operands.
- data_operandA  in  WIDTH  multiplicand.
- data_operandB  in  WIDTH  multiplier.
- data_result  out  WIDTH  low half of the product.
- data_result_hi  out  WIDTH  high half of the product.
- data_exception  out  1  low half does not represent the true product in the selected mode.
- data_resultRDY  out  1  one-cycle pulse; results are valid.
- busy  out  1  high while in RUN.

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, counter=0, product register=0. All outputs are 0 after the reset edge. Reset mid-RUN aborts the operation; no RDY pulse is produced.
- Start: ctrl_MULT=1 at any edge, in any state, with reset=0:
  - A and B are extended to EW bits: sign-extended if data_signed=1, zero-extended otherwise.
  - Product register (2*EW+1 bits) loads {0, Bext, 0}. A_ext, -A_ext, 2A_ext and -2A_ext are latched. The mode is latched.
  - counter=0, state=RUN.
  - A start during RUN or DONE aborts the current operation and restarts with the new operands.
- RUN, one iteration per edge:
  - Recode product[2:0]: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
  - Add the recoded value to the upper EW bits of the product register (EW-bit add, carry discarded).
  - Arithmetic-shift the whole register right by 2. counter increments.
  - When counter reaches NITER-1 on an iteration edge, that edge performs the final iteration and moves to DONE.
- Latency: start at edge k, final iteration at edge k+NITER (k+17 for WIDTH=32). data_resultRDY is high for exactly the cycle following edge k+NITER.
- DONE: data_resultRDY=1 for one cycle, then IDLE. busy=0 in DONE and IDLE.
- Outputs are registered and driven directly from the product register:
  - data_result = P[WIDTH-1:0] and data_result_hi = P[2*WIDTH-1:WIDTH], where P = the 2*EW-bit product excluding the Booth guard bit.
  - They hold their last value through IDLE until the next start or reset. During RUN they show intermediate values and are don't-care.
- data_exception is valid only while data_resultRDY=1 and is forced to 0 otherwise.
  - Signed: 1 iff P[2*WIDTH-1:WIDTH-1] is neither all-zeros nor all-ones.
  - Unsigned: 1 iff data_result_hi != 0.
  - A zero operand always gives exception 0.
- Operand inputs may change after the start edge without effect.

Decomposition:
- Package booth_mult_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the Booth select encoding constants (SEL_ZERO, SEL_POS1, SEL_POS2, SEL_NEG1, SEL_NEG2);
  - a function computing NITER from WIDTH.
- One sub-module: booth_recode_r4. Combinational; maps a 3-bit window to a select code and drives the EW-bit addend from the latched multiples.
- Datapath, counter and FSM live in booth_mult_param.

Test Plan:
- WIDTH=32, signed, A=7, B=-3 (0xFFFFFFFD), start at edge 0 -> busy high edges 1..17; RDY high in the cycle after edge 17; data_result=0xFFFFFFEB, data_result_hi=0xFFFFFFFF, exception=0.
- WIDTH=32, unsigned, A=B=0xFFFFFFFF -> data_result=0x00000001, data_result_hi=0xFFFFFFFE, exception=1. The same operands in signed mode -> result 0x00000001, hi 0x00000000, exception=0.
- WIDTH=32, signed, A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_result_hi=0x00000000, exception=1. Then A=0, B=0x80000000 -> result 0, exception 0.
- Restart: start A=5,B=6; assert start again at edge 8 with A=9,B=10 -> only one RDY pulse, 17 edges after edge 8, with result 90; no RDY for the first operation.
- Reset at edge 10 of RUN -> all outputs 0 after that edge, no RDY ever. A subsequent start with 3*4 completes normally with result 12.
- WIDTH=8 instance, signed, A=B=0x80 -> RDY 5 edges after start; data_result=0x00, data_result_hi=0x40, exception=1. Unsigned 200*200 -> result 0x40, hi 0x9C, exception=1.

Source files
------------

// File: rtl/booth_mult_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
package booth_mult_pkg;

  // Controller states: IDLE waits for a start, RUN iterates, DONE presents the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Booth select codes chosen by the 3-bit recoding window.
  typedef logic [2:0] sel_t;

  localparam sel_t SEL_ZERO = 3'd0;
  localparam sel_t SEL_POS1 = 3'd1;
  localparam sel_t SEL_POS2 = 3'd2;
  localparam sel_t SEL_NEG1 = 3'd3;
  localparam sel_t SEL_NEG2 = 3'd4;

  // Number of radix-4 iterations for a given operand width. The operand is
  // extended by two bits so every window of an unsigned operand is covered.
  function automatic int calc_niter(input int width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_recode_r4.sv
// Radix-4 Booth recoder: turns a 3-bit multiplier window into a select code
// and picks the matching pre-computed multiple of the multiplicand.
module booth_recode_r4
  import booth_mult_pkg::*;
#(
  parameter int EW = 34
) (
  input  logic [2:0]    window_i,
  input  logic [EW-1:0] pos1_i,
  input  logic [EW-1:0] pos2_i,
  input  logic [EW-1:0] neg1_i,
  input  logic [EW-1:0] neg2_i,
  output logic [EW-1:0] addend_o
);

  sel_t sel;

  // Map the window {b[i+1], b[i], b[i-1]} to a Booth digit.
  always_comb begin
    sel = SEL_ZERO;
    case (window_i)
      3'b000, 3'b111: sel = SEL_ZERO;
      3'b001, 3'b010: sel = SEL_POS1;
      3'b011:         sel = SEL_POS2;
      3'b100:         sel = SEL_NEG2;
      3'b101, 3'b110: sel = SEL_NEG1;
      default:        sel = SEL_ZERO;
    endcase
  end

  // Select the multiple of the multiplicand that the digit asks for.
  always_comb begin
    addend_o = '0;
    case (sel)
      SEL_POS1: addend_o = pos1_i;
      SEL_POS2: addend_o = pos2_i;
      SEL_NEG1: addend_o = neg1_i;
      SEL_NEG2: addend_o = neg2_i;
      default:  addend_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_param.sv
// Sequential radix-4 Booth multiplier with selectable signed/unsigned mode
// and a full double-width product. One Booth digit is retired per clock.
//
// Handshake: ctrl_MULT is a single-cycle start, accepted on any edge where
// reset is low, even while an operation is in flight (the old one is dropped).
// busy is high while iterating; data_resultRDY pulses for exactly one cycle
// when data_result/data_result_hi/data_exception are valid.
module booth_mult_param
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = 32  // must be even and >= 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             data_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int EW    = WIDTH + 2;
  localparam int NITER = calc_niter(WIDTH);
  localparam int CW    = $clog2(NITER + 1);
  // Product register: {accumulator (EW), multiplier (EW), Booth guard bit}.
  localparam int PW    = 2 * EW + 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  prod_q, prod_d;
  logic [EW-1:0]  pos1_q, pos1_d;
  logic [EW-1:0]  pos2_q, pos2_d;
  logic [EW-1:0]  neg1_q, neg1_d;
  logic [EW-1:0]  neg2_q, neg2_d;
  logic           mode_q, mode_d;

  logic [EW-1:0]  a_ext;
  logic [EW-1:0]  b_ext;
  logic [EW-1:0]  addend;
  logic [EW-1:0]  acc_sum;
  logic [PW-1:0]  prod_sum;
  logic [PW-1:0]  prod_iter;
  logic           last_iter;
  logic           hi_nonzero;
  logic           signed_ovf;

  // Extend the raw operands by two bits according to the requested mode.
  always_comb begin
    a_ext = data_signed ? {{2{data_operandA[WIDTH-1]}}, data_operandA}
                        : {2'b00, data_operandA};
    b_ext = data_signed ? {{2{data_operandB[WIDTH-1]}}, data_operandB}
                        : {2'b00, data_operandB};
  end

  booth_recode_r4 #(
    .EW (EW)
  ) u_recode (
    .window_i (prod_q[2:0]),
    .pos1_i   (pos1_q),
    .pos2_i   (pos2_q),
    .neg1_i   (neg1_q),
    .neg2_i   (neg2_q),
    .addend_o (addend)
  );

  // One Booth step: add the digit's multiple into the accumulator (carry out
  // dropped, the two extension bits keep it in range) then shift right by 2.
  always_comb begin
    acc_sum   = prod_q[PW-1:EW+1] + addend;
    prod_sum  = {acc_sum, prod_q[EW:0]};
    prod_iter = {{2{prod_sum[PW-1]}}, prod_sum[PW-1:2]};
    last_iter = (cnt_q == CW'(NITER - 1));
  end

  // Next-state, counter and datapath control. A start always wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    pos1_d  = pos1_q;
    pos2_d  = pos2_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
    mode_d  = mode_q;
    if (ctrl_MULT) begin
      prod_d  = {{EW{1'b0}}, b_ext, 1'b0};
      pos1_d  = a_ext;
      pos2_d  = {a_ext[EW-2:0], 1'b0};
      neg1_d  = -a_ext;
      neg2_d  = -{a_ext[EW-2:0], 1'b0};
      mode_d  = data_signed;
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          prod_d = prod_iter;
          cnt_d  = cnt_q + CW'(1);
          if (last_iter) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      pos1_q  <= '0;
      pos2_q  <= '0;
      neg1_q  <= '0;
      neg2_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      pos1_q  <= pos1_d;
      pos2_q  <= pos2_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      mode_q  <= mode_d;
    end
  end

  // Results come straight out of the product register, skipping the guard bit.
  assign data_result    = prod_q[WIDTH:1];
  assign data_result_hi = prod_q[2*WIDTH:WIDTH+1];

  // Overflow of the low half: unsigned needs a zero high half, signed needs
  // the high half plus the low half's sign bit to be a pure sign extension.
  always_comb begin
    hi_nonzero = |prod_q[2*WIDTH:WIDTH+1];
    signed_ovf = ~((&prod_q[2*WIDTH:WIDTH]) | ~(|prod_q[2*WIDTH:WIDTH]));
  end

  assign data_resultRDY = (state_q == DONE);
  assign data_exception = data_resultRDY & (mode_q ? signed_ovf : hi_nonzero);
  assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_booth_mult_param.sv
// Bench for booth_mult_param: a WIDTH=32 and a WIDTH=8 instance, table vectors,
// random vectors against a reference model, and restart/reset sequences.
module tb_booth_mult_param;

  localparam int NITER32 = 17;
  localparam int NITER8  = 5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst32, ctrl32, sgn32, exc32, rdy32, busy32;
  logic [31:0] a32, b32, lo32, hi32;
  logic        rst8, ctrl8, sgn8, exc8, rdy8, busy8;
  logic [7:0]  a8, b8, lo8, hi8;

  booth_mult_param #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(rst32), .ctrl_MULT(ctrl32), .data_signed(sgn32),
    .data_operandA(a32), .data_operandB(b32), .data_result(lo32),
    .data_result_hi(hi32), .data_exception(exc32), .data_resultRDY(rdy32),
    .busy(busy32)
  );

  booth_mult_param #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(rst8), .ctrl_MULT(ctrl8), .data_signed(sgn8),
    .data_operandA(a8), .data_operandB(b8), .data_result(lo8),
    .data_result_hi(hi8), .data_exception(exc8), .data_resultRDY(rdy8),
    .busy(busy8)
  );

  int checks = 0;
  int errors = 0;

  logic [64:0] exp_q32[$];  // {exc, hi, lo}
  logic [16:0] exp_q8[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [64:0] model32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    longint      sp;
    logic        exc;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    p  = ea * eb;
    sp = $signed(p);
    if (sgn) exc = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
    else     exc = (p[63:32] != 32'd0);
    return {exc, p};
  endfunction

  function automatic logic [16:0] model8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb, p;
    int          sp;
    logic        exc;
    ea = {{8{sgn & a[7]}}, a};
    eb = {{8{sgn & b[7]}}, b};
    p  = ea * eb;
    sp = $signed({{16{p[15]}}, p});
    if (sgn) exc = (sp > 127) || (sp < -128);
    else     exc = (p[15:8] != 8'd0);
    return {exc, p};
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(negedge clock) begin
    logic [64:0] e;
    if (rdy32) begin
      if (exp_q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdy32_unexpected actual=rdy required=no_rdy");
      end else begin
        e = exp_q32.pop_front();
        chk("lo32", 64'(lo32), 64'(e[31:0]));
        chk("hi32", 64'(hi32), 64'(e[63:32]));
        chk("exc32", 64'(exc32), 64'(e[64]));
      end
    end else begin
      chk("exc32_idle", 64'(exc32), 64'd0);
    end
  end

  always @(negedge clock) begin
    logic [16:0] e;
    if (rdy8) begin
      if (exp_q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdy8_unexpected actual=rdy required=no_rdy");
      end else begin
        e = exp_q8.pop_front();
        chk("lo8", 64'(lo8), 64'(e[7:0]));
        chk("hi8", 64'(hi8), 64'(e[15:8]));
        chk("exc8", 64'(exc8), 64'(e[16]));
      end
    end else begin
      chk("exc8_idle", 64'(exc8), 64'd0);
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic start32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    ctrl32 = 1'b1; sgn32 = sgn; a32 = a; b32 = b;
    @(posedge clock);
    @(negedge clock);
    ctrl32 = 1'b0; sgn32 = 1'($urandom_range(0, 1)); a32 = $urandom; b32 = $urandom;
  endtask

  task automatic watch32(input int max_cyc, output int lat, output int n_rdy, output int n_busy);
    lat = -1; n_rdy = 0; n_busy = 0;
    for (int j = 0; j < max_cyc; j++) begin
      if (j > 0) @(negedge clock);
      if (rdy32) begin
        if (lat < 0) lat = j;
        n_rdy++;
      end
      if (busy32) n_busy++;
    end
  endtask

  task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [64:0] exp_v, input string tag);
    int lat, nr, nb;
    exp_q32.push_back(exp_v);
    start32(sgn, a, b);
    watch32(NITER32 + 4, lat, nr, nb);
    chk({tag, "_lat"}, 64'(lat), 64'(NITER32));
    chk({tag, "_nrdy"}, 64'(nr), 64'd1);
    chk({tag, "_nbusy"}, 64'(nb), 64'(NITER32));
    chk({tag, "_hold_lo"}, 64'(lo32), 64'(exp_v[31:0]));
  endtask

  task automatic start8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
    ctrl8 = 1'b1; sgn8 = sgn; a8 = a; b8 = b;
    @(posedge clock);
    @(negedge clock);
    ctrl8 = 1'b0; sgn8 = 1'($urandom_range(0, 1)); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic run8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                      input logic [16:0] exp_v, input string tag);
    int lat, nr, nb;
    lat = -1; nr = 0; nb = 0;
    exp_q8.push_back(exp_v);
    start8(sgn, a, b);
    for (int j = 0; j < NITER8 + 4; j++) begin
      if (j > 0) @(negedge clock);
      if (rdy8) begin
        if (lat < 0) lat = j;
        nr++;
      end
      if (busy8) nb++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(NITER8));
    chk({tag, "_nrdy"}, 64'(nr), 64'd1);
    chk({tag, "_nbusy"}, 64'(nb), 64'(NITER8));
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic        sgn;
    logic [31:0] a, b, lo, hi;
    logic        exc;
  } vec32_t;

  typedef struct {
    logic       sgn;
    logic [7:0] a, b, lo, hi;
    logic       exc;
  } vec8_t;

  vec32_t tab32[10];
  vec8_t  tab8[5];

  initial begin
    int lat, nr, nb;
    logic        rs;
    logic [31:0] ra, rb;
    logic [7:0]  ra8, rb8;

    tab32[0] = '{1'b1, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0};
    tab32[1] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1};
    tab32[2] = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    tab32[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1};
    tab32[4] = '{1'b1, 32'h00000000,   32'h80000000, 32'h00000000, 32'h00000000, 1'b0};
    tab32[5] = '{1'b0, 32'h00010000,   32'h00010000, 32'h00000000, 32'h00000001, 1'b1};
    tab32[6] = '{1'b1, 32'h7FFFFFFF,   32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 1'b1};
    tab32[7] = '{1'b1, 32'h80000000,   32'h80000000, 32'h00000000, 32'h40000000, 1'b1};
    tab32[8] = '{1'b1, 32'hFFFF8000,   32'h00010000, 32'h80000000, 32'hFFFFFFFF, 1'b0};
    tab32[9] = '{1'b0, 32'h12345678,   32'h00000000, 32'h00000000, 32'h00000000, 1'b0};

    tab8[0] = '{1'b1, 8'h80, 8'h80, 8'h00, 8'h40, 1'b1};
    tab8[1] = '{1'b0, 8'hC8, 8'hC8, 8'h40, 8'h9C, 1'b1};
    tab8[2] = '{1'b1, 8'hFF, 8'h80, 8'h80, 8'h00, 1'b1};
    tab8[3] = '{1'b1, 8'h0B, 8'hF5, 8'h87, 8'hFF, 1'b0};
    tab8[4] = '{1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1};

    rst32 = 1'b1; ctrl32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    rst8  = 1'b1; ctrl8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clock);
    rst32 = 1'b0; rst8 = 1'b0;

    // Reset state.
    chk("rst_lo32", 64'(lo32), 64'd0);
    chk("rst_hi32", 64'(hi32), 64'd0);
    chk("rst_rdy32", 64'(rdy32), 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_lo8", 64'(lo8), 64'd0);
    chk("rst_hi8", 64'(hi8), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);

    // Table vectors.
    for (int i = 0; i < 10; i++)
      run32(tab32[i].sgn, tab32[i].a, tab32[i].b,
            {tab32[i].exc, tab32[i].hi, tab32[i].lo}, $sformatf("tab32_%0d", i));
    for (int i = 0; i < 5; i++)
      run8(tab8[i].sgn, tab8[i].a, tab8[i].b,
           {tab8[i].exc, tab8[i].hi, tab8[i].lo}, $sformatf("tab8_%0d", i));

    // Random vectors against the model.
    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(0, 1)); ra = $urandom; rb = $urandom;
      run32(rs, ra, rb, model32(rs, ra, rb), $sformatf("rnd32_%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1)); ra8 = 8'($urandom); rb8 = 8'($urandom);
      run8(rs, ra8, rb8, model8(rs, ra8, rb8), $sformatf("rnd8_%0d", i));
    end

    // Restart mid-RUN: the first operation must never signal ready.
    start32(1'b1, 32'd5, 32'd6);
    watch32(7, lat, nr, nb);
    chk("restart_first_nrdy", 64'(nr), 64'd0);
    @(negedge clock);
    exp_q32.push_back(model32(1'b0, 32'd9, 32'd10));
    start32(1'b0, 32'd9, 32'd10);
    watch32(NITER32 + 6, lat, nr, nb);
    chk("restart_lat", 64'(lat), 64'(NITER32));
    chk("restart_nrdy", 64'(nr), 64'd1);
    chk("restart_lo", 64'(lo32), 64'd90);

    // Start on the DONE cycle: first result is delivered, second follows.
    exp_q32.push_back(model32(1'b1, 32'hFFFFFFF0, 32'd3));
    start32(1'b1, 32'hFFFFFFF0, 32'd3);
    watch32(NITER32 + 1, lat, nr, nb);
    chk("done_restart_first_lat", 64'(lat), 64'(NITER32));
    exp_q32.push_back(model32(1'b0, 32'hDEADBEEF, 32'h00001234));
    start32(1'b0, 32'hDEADBEEF, 32'h00001234);
    watch32(NITER32 + 4, lat, nr, nb);
    chk("done_restart_lat", 64'(lat), 64'(NITER32));
    chk("done_restart_nrdy", 64'(nr), 64'd1);

    // Reset asserted on edge 10 of RUN aborts the operation.
    start32(1'b1, 32'h00012345, 32'h00000777);
    watch32(9, lat, nr, nb);
    chk("abort_pre_nrdy", 64'(nr), 64'd0);
    @(negedge clock);
    rst32 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rst32 = 1'b0;
    chk("abort_lo32", 64'(lo32), 64'd0);
    chk("abort_hi32", 64'(hi32), 64'd0);
    chk("abort_exc32", 64'(exc32), 64'd0);
    chk("abort_rdy32", 64'(rdy32), 64'd0);
    chk("abort_busy32", 64'(busy32), 64'd0);
    watch32(25, lat, nr, nb);
    chk("abort_post_nrdy", 64'(nr), 64'd0);
    chk("abort_post_nbusy", 64'(nb), 64'd0);
    run32(1'b0, 32'd3, 32'd4, {1'b0, 32'd0, 32'd12}, "after_reset");

    repeat (2) @(negedge clock);
    chk("q32_drained", 64'(exp_q32.size()), 64'd0);
    chk("q8_drained", 64'(exp_q8.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
